// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: ESP-PSRAM64H-style device emulator. Decodes SPI/QPI
// commands from an oversampled sclk/ce/sio link and serves quad writes (0x38)
// and fast quad reads (0xEB) from an internal byte array. Pad tristates live
// in the wrapper; this block only produces data and per-pad enables.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a ce falling edge to start a transaction
// CMD      | shifting in the 8-bit opcode (8 SPI bits or 2 QPI nibbles)
// ADDR     | shifting in 6 address nibbles, A[23:20] first
// WAIT     | counting dummy sclk rises before read data
// WR_DATA  | taking write nibbles on rises, committing a byte per 2 nibbles
// RD_DATA  | driving read nibbles on falls
// IGNORE   | swallowing clocks until ce returns high
module psram_qpi_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_CYCLES = 6,
   parameter bit INIT_ZERO   = 1'b1
) (
   input  logic       clk_mem,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ce,
   input  logic [3:0] sio_in,
   output logic [3:0] sio_out,
   output logic [3:0] sio_oe,
   output logic       qpi_mode,
   output logic       busy,
   output logic       cmd_err
);

   localparam int MEM_SIZE = 1 << ADDR_BITS;
   localparam logic [7:0] INIT_BYTE = INIT_ZERO ? 8'h00 : 8'hxx;
   localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
   localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES - 1);

   localparam logic [7:0] OP_RSTEN    = 8'h66;
   localparam logic [7:0] OP_RST      = 8'h99;
   localparam logic [7:0] OP_QPI_ON   = 8'h35;
   localparam logic [7:0] OP_QPI_OFF  = 8'hF5;
   localparam logic [7:0] OP_WRITE    = 8'h38;
   localparam logic [7:0] OP_READ     = 8'hEB;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WAIT, S_WR, S_RD, S_IGNORE
   } state_t;

   state_t                 state_q, state_d;
   logic                   sclk_q, ce_q;
   logic [6:0]             sh_q, sh_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [7:0]             wait_q, wait_d;
   logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
   logic                   lo_q, lo_d;
   logic [3:0]             hold_q, hold_d;
   logic                   is_rd_q, is_rd_d;
   logic                   qpi_q, qpi_d;
   logic                   rsten_q, rsten_d;
   logic [3:0]             oe_q, oe_d;
   logic [3:0]             out_q, out_d;
   logic                   err_q, err_d;
   logic                   wr_en;

   logic                   rise, fall;
   logic [7:0]             cmd_byte;
   logic                   cmd_last;
   logic [7:0]             mem_rd;

   // The array is never touched by reset, so its contents survive controller resets.
   logic [7:0] mem_q [MEM_SIZE] = '{default: INIT_BYTE};

   assign rise     = sclk & ~sclk_q;
   assign fall     = ~sclk & sclk_q;
   assign cmd_byte = qpi_q ? {sh_q[3:0], sio_in} : {sh_q, sio_in[0]};
   assign cmd_last = qpi_q ? (cnt_q == 3'd1) : (cnt_q == 3'd7);
   assign mem_rd   = mem_q[ptr_q];

   assign sio_out  = out_q;
   assign sio_oe   = oe_q;
   assign qpi_mode = qpi_q;
   assign cmd_err  = err_q;
   assign busy     = ~ce & (state_q != S_IDLE);

   // Next-state and output decode; ce high overrides any sclk edge in the same cycle.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      ptr_d   = ptr_q;
      lo_d    = lo_q;
      hold_d  = hold_q;
      is_rd_d = is_rd_q;
      qpi_d   = qpi_q;
      rsten_d = rsten_q;
      oe_d    = oe_q;
      out_d   = out_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;

      if (ce) begin
         state_d = S_IDLE;
         cnt_d   = 3'd0;
         lo_d    = 1'b0;
         oe_d    = 4'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Only a real ce fall starts a command, so traffic left over
               // after a mid-transaction reset is not misread as an opcode.
               if (ce_q) begin
                  state_d = S_CMD;
                  cnt_d   = 3'd0;
                  if (rise) begin
                     sh_d  = cmd_byte[6:0];
                     cnt_d = 3'd1;
                  end
               end
            end
            S_CMD: begin
               if (rise) begin
                  sh_d = cmd_byte[6:0];
                  if (cmd_last) begin
                     cnt_d   = 3'd0;
                     rsten_d = 1'b0;
                     state_d = S_IGNORE;
                     case (cmd_byte)
                        OP_RSTEN:  rsten_d = 1'b1;
                        OP_RST:    if (rsten_q) qpi_d = 1'b0;
                        OP_QPI_ON: qpi_d = 1'b1;
                        OP_QPI_OFF: begin
                           if (qpi_q) qpi_d = 1'b0;
                           else       err_d = 1'b1;
                        end
                        OP_WRITE, OP_READ: begin
                           if (qpi_q) begin
                              state_d = S_ADDR;
                              is_rd_d = (cmd_byte == OP_READ);
                           end else begin
                              err_d = 1'b1;
                           end
                        end
                        default:   err_d = 1'b1;
                     endcase
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            S_ADDR: begin
               if (rise) begin
                  // Only the low ADDR_BITS survive the shift: address is taken modulo array size.
                  ptr_d = {ptr_q[ADDR_BITS-5:0], sio_in};
                  if (cnt_q == 3'd5) begin
                     cnt_d = 3'd0;
                     lo_d  = 1'b0;
                     if (!is_rd_q) begin
                        state_d = S_WR;
                     end else if (WAIT_CYCLES == 0) begin
                        state_d = S_RD;
                     end else begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_INIT;
                     end
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            S_WAIT: begin
               if (rise) begin
                  if (wait_q == 8'd0) state_d = S_RD;
                  else                wait_d  = wait_q - 8'd1;
               end
            end
            S_RD: begin
               // Data changes on falls so it is stable over the whole sclk-high phase.
               if (fall) begin
                  oe_d = 4'hF;
                  if (!lo_q) begin
                     out_d = mem_rd[7:4];
                     lo_d  = 1'b1;
                  end else begin
                     out_d = mem_rd[3:0];
                     lo_d  = 1'b0;
                     ptr_d = ptr_q + PTR_ONE;
                  end
               end
            end
            S_WR: begin
               if (rise) begin
                  if (!lo_q) begin
                     hold_d = sio_in;
                     lo_d   = 1'b1;
                  end else begin
                     wr_en  = 1'b1;
                     lo_d   = 1'b0;
                     ptr_d  = ptr_q + PTR_ONE;
                  end
               end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk_mem) begin
      if (rst) begin
         state_q <= S_IDLE;
         sclk_q  <= 1'b0;
         ce_q    <= 1'b0;
         sh_q    <= '0;
         cnt_q   <= '0;
         wait_q  <= '0;
         ptr_q   <= '0;
         lo_q    <= 1'b0;
         hold_q  <= '0;
         is_rd_q <= 1'b0;
         qpi_q   <= 1'b0;
         rsten_q <= 1'b0;
         oe_q    <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sclk_q  <= sclk;
         ce_q    <= ce;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         ptr_q   <= ptr_d;
         lo_q    <= lo_d;
         hold_q  <= hold_d;
         is_rd_q <= is_rd_d;
         qpi_q   <= qpi_d;
         rsten_q <= rsten_d;
         oe_q    <= oe_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   // Commit a write byte once its second nibble arrives; reset blocks the commit.
   always_ff @(posedge clk_mem) begin
      if (wr_en && !rst) mem_q[ptr_q] <= {hold_q, sio_in};
   end

endmodule

// File: doc/psram_qpi_responder.md
Name: psram_qpi_responder

Overview:
- Synthesizable ESP-PSRAM64H-style device emulator for the QPI PSRAM controller: the responder end of the same SPI/QPI link.
- It decodes SPI and QPI commands from sclk/ce/sio, and serves quad writes (0x38) and fast quad reads (0xEB) from an internal byte array.
- It is used in simulation benches and in FPGA loopback builds where no PSRAM chip is fitted. A bench or top wrapper adds the tristate buffers.

Parameters:
- ADDR_BITS, 12: internal array is 2^ADDR_BITS bytes. The 24-bit address is used modulo the array size.
- WAIT_CYCLES, 6: dummy SCLK cycles between the last address nibble and the first read nibble.
- INIT_ZERO, 1: when 1, the array is zero-initialised at configuration. Reset does not clear the array.

Ports:
- clk_mem  in  1  sampling clock; must be at least 2x the sclk frequency (sclk is driven from clk_mem flops).
- rst  in  1  reset rst, synchronous, active-high.
- sclk  in  1  serial clock from the controller.
- ce  in  1  chip enable, active-low.
- sio_in  in  4  pad inputs: bit0=mosi/SI, bit1=miso/SO, bit2=sio2, bit3=sio3.
- sio_out  out  4  pad output data, same bit mapping.
- sio_oe  out  4  per-pad output enable, 1 = drive.
- qpi_mode  out  1  1 while the device is in QPI mode.
- busy  out  1  1 while ce is low and the device is not in IDLE.
- cmd_err  out  1  one-cycle pulse when an unsupported opcode is received.

Behaviour:
- Edge detection:
  - Register sclk_q and ce_q each clk_mem.
  - rise = sclk & ~sclk_q; fall = ~sclk & sclk_q.
  - All protocol action happens on rise/fall cycles only.
- Reset values: state=IDLE, qpi_mode=0, rsten=0, sio_oe=0, sio_out=0, cmd_err=0, busy=0. Array contents are kept.
- ce high, at any time and in any state:
  - Next cycle: state=IDLE, sio_oe=0, bit counters cleared.
  - A partial write byte is discarded. The read pointer is dropped.
- Command phase (CMD):
  - SPI mode: one bit per rise, taken from sio_in[0], MSB first, 8 rises.
  - QPI mode: one nibble per rise, high nibble first, nibble = {sio_in[3],sio_in[2],sio_in[1],sio_in[0]}, 2 rises.
- Opcode decode, applied when the 8th opcode bit is complete:
  - 0x66: set rsten; go to IGNORE.
  - 0x99: if rsten is set, qpi_mode<=0. Go to IGNORE. rsten<=0.
  - 0x35: qpi_mode<=1; go to IGNORE.
  - 0xF5 in QPI mode: qpi_mode<=0; go to IGNORE.
  - 0x38 or 0xEB in QPI mode: go to ADDR.
  - Any other opcode, or 0x38/0xEB in SPI mode: pulse cmd_err; go to IGNORE.
  - Every opcode other than 0x66 clears rsten.
- ADDR: 6 nibbles on rises, A[23:20] first. Then go to WR_DATA (0x38) or WAIT (0xEB).
- WAIT: count WAIT_CYCLES rises, then go to RD_DATA.
- RD_DATA:
  - sio_oe=4'hF from the fall following the last wait rise until ce goes high.
  - On each fall, drive the next nibble: high nibble of mem[ptr], then low nibble.
  - ptr increments after each low nibble and wraps at 2^ADDR_BITS-1 -> 0.
  - sio_out changes only on fall cycles, so it is stable throughout each sclk-high phase.
- WR_DATA:
  - Nibbles arrive on rises, high nibble first.
  - The byte is written to mem[ptr] on the rise of its second nibble; ptr then increments with the same wrap rule.
- IGNORE: consume further clocks with no effect until ce goes high.
- sio_oe is 0 in every state except RD_DATA.
- Simultaneous ce rise and sclk edge: ce wins and the edge is ignored.
- rst asserted mid-transaction: IDLE and SPI mode on the next cycle. A write byte that is not yet complete is not written.

Test Plan:
- Init sequence: SPI 0x66, ce high, SPI 0x99, ce high, SPI 0x35 -> qpi_mode=1, cmd_err never pulses, sio_oe stays 0.
- Quad write then read:
  - QPI 0x38 at addr 0x000010 with data A5 3C FF 00.
  - Then QPI 0xEB at 0x000010 with 6 dummy cycles.
  - Controller captures on sclk-high cycles: A5 3C FF 00.
- Wrap-around: with ADDR_BITS=12, write 11 22 at 0x000FFF; read 2 bytes at 0x000FFF -> 11 22. A 1-byte read at 0x000000 -> 22.
- Address aliasing: write 0x77 at 0x123456; read at 0x000456 -> 0x77.
- Abort cases:
  - ce high after one nibble of a write byte -> mem unchanged.
  - ce high mid-read -> sio_oe=0 one clk_mem cycle later.
  - rst during a read -> qpi_mode=0, state=IDLE.
- Command guards:
  - SPI 0x99 without a preceding 0x66 -> no mode change.
  - 0xEB in SPI mode -> one cmd_err pulse, no drive.
  - QPI 0xF5 -> qpi_mode=0.
